fusion_operand_packer: RTL
==========================

# fusion_operand_packer

Producer-side front end for the bit-fusion multiply array. Accepts a stream of low-precision activation/weight element pairs over a valid/ready handshake and packs them into the 4-bit `a`/`b` bit-brick words, with matching `mode`/`sign_mode`, that a fusion unit consumes. Packing depends on the fusion mode: the 2b×2b, 2b×1b, 1b×2b or 1b×1b products are placed so that the fusion unit's output equals the dot product of the packed elements. Sits between the operand buffers and the fusion array.

## Interface
Parameters:
- `ACT_WIDTH`, 4: packed activation word width. Only 4 is legal.
- `WGT_WIDTH`, 4: packed weight word width. Only 4 is legal.
- `CNT_WIDTH`, 32: width of the statistics counters (see Configuration).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_mode` in 2: 0 = 2K×2K, 1 = 2K×1K, 2 = 1K×2K, 3 = 1K×1K.
- `cfg_sign_mode` in 2: bit1 = 1 means activations unsigned; bit0 = 1 means weights unsigned.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_act` in 2: activation element.
- `in_wgt` in 2: weight element.
- `in_last` in 1: closes the current word early.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_a` out 4, `out_b` out 4: packed bricks.
- `out_mode` out 2, `out_sign_mode` out 2: configuration aligned with the word.
- `out_last` out 1: the word was closed by `in_last`.
- `stat_words` out CNT_WIDTH, `stat_padded` out CNT_WIDTH: present only with the macro.

## Operation
- Elements per word N: mode 0 → 1, mode 1 → 2, mode 2 → 2, mode 3 → 4.
- Slot count k runs 0..N-1.
- `cfg_mode` and `cfg_sign_mode` are sampled when the element with k = 0 is accepted, and held for the word. Changes mid-word are ignored until the next word.
- Slot placement (A = `in_act`, B = `in_wgt`, e = slot index):
  - Mode 0: a = {A1,A0,A1,A0}, b = {B1,B1,B0,B0}.
  - Mode 1: a[2e+1:2e] = A[1:0], b[2e+1:2e] = {B0,B0}.
  - Mode 2: a[e] = a[e+2] = A0, b[e] = B0, b[e+2] = B1.
  - Mode 3: a[e] = A0, b[e] = B0.
- Unused input bits are ignored. Unfilled slots are zero.
- A word closes when k reaches N-1, or when `in_last` is set on an accepted element. Closing loads the output register, resets k to 0, and sets `out_last` to `in_last`.
- FSM:
  - FILL: k > 0, partial word held.
  - IDLE: k = 0, no partial word.
  - The output register is an independent full/empty flag.
- `in_ready` = !`out_valid` || `out_ready`. This is a combinational path from `out_ready`.
- Signedness is not altered: `out_sign_mode` carries the sampled `cfg_sign_mode`. The fusion unit derives sign from mode and sign_mode.

## Timing
- Reset values: `out_valid`=0, `out_a`=0, `out_b`=0, `out_mode`=0, `out_sign_mode`=0, `out_last`=0, k=0, stats=0.
- A word-closing element accepted in cycle t gives `out_valid`=1 in cycle t+1.
- Throughput is one element per cycle and one word per N cycles with no stalls.
- Output is held stable while `out_valid` && !`out_ready`.
- Simultaneous drain and close in the same cycle: the new word replaces the old one, with no bubble.
- `in_last` with k = 0 (including mode 0) emits that single element with `out_last`=1.
- `reset` mid-word discards the partial word and any pending output in the next cycle.

## Configuration
- `FUSION_PACKER_STATS_EN` defined:
  - `stat_words` increments on every output handshake.
  - `stat_padded` increments on every handshake of a word that had unfilled slots.
  - Both wrap at 2^CNT_WIDTH.
  - Both clear on reset.
- Undefined: the stat ports and counters are absent. All other behaviour is identical.

## Test plan
- Mode 0, sign 0: element (act=11, wgt=10) → next cycle `out_a`=1111, `out_b`=1100, `out_mode`=0.
- Mode 1: elements (01,x1) then (10,x0) → `out_a`=1001, `out_b`=0011, `out_valid` one cycle after the second accept.
- Mode 2: elements (x1,10) then (x0,01) → `out_a`=0101, `out_b`=0110.
- Mode 3: acts 1,0,1 and wgts 1,1,0, `in_last` on the third element → `out_a`=0101, `out_b`=0011, `out_last`=1; `stat_padded` increments.
- Backpressure with a word pending and `out_ready`=0 for 5 cycles → `in_ready`=0 and outputs stable. Then set `out_ready`=1 → handshake, then `in_ready`=1.
- Mode 3 with two elements accepted:
  - Change `cfg_mode` to 0 → no effect on the current word.
  - Assert `reset` → next cycle `out_valid`=0, k=0, and a fresh mode-0 word packs correctly.

Source files
------------

// File: rtl/fusion_operand_packer.sv
// Packs 2-bit activation/weight element pairs into 4-bit bit-fusion bricks with aligned mode/sign_mode.
// Optional statistics counters (stat_words, stat_padded) are built only when FUSION_PACKER_STATS_EN is defined.
module fusion_operand_packer #(
    parameter int ACT_WIDTH = 4,
    parameter int WGT_WIDTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cfg_mode,
    input  logic [1:0]           cfg_sign_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_act,
    input  logic [1:0]           in_wgt,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACT_WIDTH-1:0] out_a,
    output logic [WGT_WIDTH-1:0] out_b,
    output logic [1:0]           out_mode,
    output logic [1:0]           out_sign_mode,
    output logic                 out_last
`ifdef FUSION_PACKER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_words,
    output logic [CNT_WIDTH-1:0] stat_padded
`endif
);

    localparam logic [1:0] MODE_2X2 = 2'd0;
    localparam logic [1:0] MODE_2X1 = 2'd1;
    localparam logic [1:0] MODE_1X2 = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  sign_q, sign_d;
    logic [3:0]  acc_a_q, acc_a_d;
    logic [3:0]  acc_b_q, acc_b_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_a_q, out_a_d;
    logic [3:0]  out_b_q, out_b_d;
    logic [1:0]  out_mode_q, out_mode_d;
    logic [1:0]  out_sign_q, out_sign_d;
    logic        out_last_q, out_last_d;

    logic [1:0]  eff_mode;
    logic [1:0]  eff_sign;
    logic [1:0]  last_k;
    logic [3:0]  slot_hit;
    logic [3:0]  slot_a;
    logic [3:0]  slot_b;
    logic [3:0]  word_a;
    logic [3:0]  word_b;
    logic        accept;
    logic        close;
    logic        drain;

    // Only 4-bit bricks and non-empty counters are meaningful; no legal build elaborates this block.
    if (ACT_WIDTH != 4 || WGT_WIDTH != 4 || CNT_WIDTH < 1) begin : g_illegal_params
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // The first element of a word uses the live configuration; later ones use the held copy.
    assign eff_mode = (state_q == ST_IDLE) ? cfg_mode : mode_q;
    assign eff_sign = (state_q == ST_IDLE) ? cfg_sign_mode : sign_q;

    always_comb begin
        last_k = 2'd3;
        case (eff_mode)
            MODE_2X2: last_k = 2'd0;
            MODE_2X1: last_k = 2'd1;
            MODE_1X2: last_k = 2'd1;
            default:  last_k = 2'd3;
        endcase
    end

    assign close = accept && (in_last || (k_q == last_k));

    // Per-bit placement of the current element into its slot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_brick_bit
        assign slot_hit[gi] = (k_q == 2'(gi));
        assign slot_a[gi] = (eff_mode == MODE_2X2) ? in_act[gi % 2] :
                            (eff_mode == MODE_2X1) ? (slot_hit[gi / 2] & in_act[gi % 2]) :
                            (eff_mode == MODE_1X2) ? (slot_hit[gi % 2] & in_act[0]) :
                                                     (slot_hit[gi] & in_act[0]);
        assign slot_b[gi] = (eff_mode == MODE_2X2) ? in_wgt[gi / 2] :
                            (eff_mode == MODE_2X1) ? (slot_hit[gi / 2] & in_wgt[0]) :
                            (eff_mode == MODE_1X2) ? (slot_hit[gi % 2] & in_wgt[gi / 2]) :
                                                     (slot_hit[gi] & in_wgt[0]);
    end

    assign word_a = acc_a_q | slot_a;
    assign word_b = acc_b_q | slot_b;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_mode_d  = out_mode_q;
        out_sign_d  = out_sign_q;
        out_last_d  = out_last_q;

        if (drain) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            mode_d = eff_mode;
            sign_d = eff_sign;
            if (close) begin
                state_d     = ST_IDLE;
                k_d         = 2'd0;
                acc_a_d     = 4'd0;
                acc_b_d     = 4'd0;
                out_valid_d = 1'b1;
                out_a_d     = word_a;
                out_b_d     = word_b;
                out_mode_d  = eff_mode;
                out_sign_d  = eff_sign;
                out_last_d  = in_last;
            end else begin
                state_d = ST_FILL;
                k_d     = k_q + 2'd1;
                acc_a_d = word_a;
                acc_b_d = word_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            mode_q      <= 2'd0;
            sign_q      <= 2'd0;
            acc_a_q     <= 4'd0;
            acc_b_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_a_q     <= 4'd0;
            out_b_q     <= 4'd0;
            out_mode_q  <= 2'd0;
            out_sign_q  <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_mode_q  <= out_mode_d;
            out_sign_q  <= out_sign_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_a         = out_a_q;
    assign out_b         = out_b_q;
    assign out_mode      = out_mode_q;
    assign out_sign_mode = out_sign_q;
    assign out_last      = out_last_q;

`ifdef FUSION_PACKER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 out_padded_q;
    logic [CNT_WIDTH-1:0] words_q;
    logic [CNT_WIDTH-1:0] padded_cnt_q;

    // A word is padded when it closed before its last slot was filled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_padded_q <= 1'b0;
            words_q      <= '0;
            padded_cnt_q <= '0;
        end else begin
            if (close) begin
                out_padded_q <= (k_q != last_k);
            end
            if (drain) begin
                words_q <= words_q + CNT_ONE;
                if (out_padded_q) begin
                    padded_cnt_q <= padded_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign stat_words  = words_q;
    assign stat_padded = padded_cnt_q;
`endif

endmodule
